// File: rtl/raster_frame_sequencer_if.sv
// rtl/raster_frame_sequencer_if.sv - triangle stream channel into the frame sequencer
interface raster_frame_sequencer_if;
  logic             tri_valid;
  logic             tri_ready;
  logic             tri_last;
  logic [2:0][31:0] tri_p1;
  logic [2:0][31:0] tri_p2;
  logic [2:0][31:0] tri_p3;

  modport master (
    output tri_valid, tri_last, tri_p1, tri_p2, tri_p3,
    input  tri_ready
  );

  modport slave (
    input  tri_valid, tri_last, tri_p1, tri_p2, tri_p3,
    output tri_ready
  );
endinterface

// File: rtl/raster_frame_sequencer.sv
// rtl/raster_frame_sequencer.sv - per-frame clear/launch/watchdog sequencer around one rasterizer
module raster_frame_sequencer #(
  parameter int FB_WIDTH  = 640,
  parameter int FB_HEIGHT = 480,
  parameter int TIMEOUT   = 1048576
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic                      clear_en,
  input  logic [3:0]                clear_color,
  raster_frame_sequencer_if.slave   tri_s,
  output logic                      rast_start,
  output logic [2:0][31:0]          rast_p1,
  output logic [2:0][31:0]          rast_p2,
  output logic [2:0][31:0]          rast_p3,
  input  logic                      rast_done,
  input  logic [9:0]                rast_fb_x,
  input  logic [8:0]                rast_fb_y,
  input  logic [3:0]                rast_data,
  input  logic                      rast_fb_we,
  output logic [9:0]                fb_x,
  output logic [8:0]                fb_y,
  output logic [3:0]                data,
  output logic                      fb_we,
  output logic                      busy,
  output logic                      frame_done,
  output logic [15:0]               tri_count,
  output logic                      timeout_err
);

  localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [9:0]      X_LAST  = 10'(FB_WIDTH - 1);
  localparam logic [8:0]      Y_LAST  = 9'(FB_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCEPT,
    S_LAUNCH,
    S_RASTER,
    S_FINISH
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [9:0]      clr_x;
  logic [8:0]      clr_y;
  logic [3:0]      clr_color;
  logic            last_q;
  logic            seen_busy;
  logic [WD_W-1:0] wd_cnt;

  logic accept;
  logic clear_end;
  logic rast_complete;
  logic rast_abort;
  logic rast_exit;

  // Event decodes; a done level is only trusted once the rasterizer has been seen busy.
  always_comb begin
    accept        = (state == S_ACCEPT) && tri_s.tri_valid;
    clear_end     = (clr_x == X_LAST) && (clr_y == Y_LAST);
    rast_complete = rast_done && seen_busy;
    rast_abort    = !rast_complete && (wd_cnt == WD_LAST);
    rast_exit     = rast_complete || rast_abort;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic plus handshake outputs and framebuffer port mux.
  always_comb begin
    state_nxt       = state;
    tri_s.tri_ready = 1'b0;
    rast_start      = 1'b0;
    frame_done      = 1'b0;
    busy            = 1'b1;
    fb_we           = 1'b0;
    fb_x            = '0;
    fb_y            = '0;
    data            = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (frame_start) begin
          state_nxt = clear_en ? S_CLEAR : S_ACCEPT;
        end
      end
      S_CLEAR: begin
        fb_we = 1'b1;
        fb_x  = clr_x;
        fb_y  = clr_y;
        data  = clr_color;
        if (clear_end) begin
          state_nxt = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        tri_s.tri_ready = 1'b1;
        if (tri_s.tri_valid) begin
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        rast_start = 1'b1;
        state_nxt  = S_RASTER;
      end
      S_RASTER: begin
        fb_we = rast_fb_we;
        fb_x  = rast_fb_x;
        fb_y  = rast_fb_y;
        data  = rast_data;
        if (rast_exit) begin
          state_nxt = last_q ? S_FINISH : S_ACCEPT;
        end
      end
      S_FINISH: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Frame datapath: clear scan counters, vertex latch, watchdog and frame statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_x       <= '0;
      clr_y       <= '0;
      clr_color   <= '0;
      last_q      <= 1'b0;
      seen_busy   <= 1'b0;
      wd_cnt      <= '0;
      rast_p1     <= '0;
      rast_p2     <= '0;
      rast_p3     <= '0;
      tri_count   <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            clr_color   <= clear_color;
            clr_x       <= '0;
            clr_y       <= '0;
            tri_count   <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (clr_x == X_LAST) begin
            clr_x <= '0;
            clr_y <= clr_y + 9'd1;
          end else begin
            clr_x <= clr_x + 10'd1;
          end
        end
        S_ACCEPT: begin
          if (accept) begin
            rast_p1 <= tri_s.tri_p1;
            rast_p2 <= tri_s.tri_p2;
            rast_p3 <= tri_s.tri_p3;
            last_q  <= tri_s.tri_last;
          end
        end
        S_LAUNCH: begin
          wd_cnt    <= '0;
          seen_busy <= 1'b0;
        end
        S_RASTER: begin
          if (!rast_done) begin
            seen_busy <= 1'b1;
          end
          wd_cnt <= wd_cnt + WD_W'(1);
          if (rast_exit) begin
            if (tri_count != 16'hFFFF) begin
              tri_count <= tri_count + 16'd1;
            end
            if (rast_abort) begin
              timeout_err <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_raster_frame_sequencer.sv
// tb/tb_raster_frame_sequencer.sv - randomized bench for raster_frame_sequencer with a frame-level model
module tb_raster_frame_sequencer;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             frame_start;
  logic             clear_en;
  logic [3:0]       clear_color;
  logic             rast_start;
  logic [2:0][31:0] rast_p1, rast_p2, rast_p3;
  logic             rast_done;
  logic [9:0]       rast_fb_x;
  logic [8:0]       rast_fb_y;
  logic [3:0]       rast_data;
  logic             rast_fb_we;
  logic [9:0]       fb_x;
  logic [8:0]       fb_y;
  logic [3:0]       data;
  logic             fb_we, busy, frame_done, timeout_err;
  logic [15:0]      tri_count;

  raster_frame_sequencer_if tri_if ();

  raster_frame_sequencer #(.FB_WIDTH(W), .FB_HEIGHT(H), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .clear_en(clear_en),
    .clear_color(clear_color), .tri_s(tri_if), .rast_start(rast_start),
    .rast_p1(rast_p1), .rast_p2(rast_p2), .rast_p3(rast_p3), .rast_done(rast_done),
    .rast_fb_x(rast_fb_x), .rast_fb_y(rast_fb_y), .rast_data(rast_data),
    .rast_fb_we(rast_fb_we), .fb_x(fb_x), .fb_y(fb_y), .data(data), .fb_we(fb_we),
    .busy(busy), .frame_done(frame_done), .tri_count(tri_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rdy, rs, we, busy, fd, terr;
    logic [9:0]       x;
    logic [8:0]       y;
    logic [3:0]       d;
    logic [15:0]      cnt;
    logic [2:0][31:0] p1, p2, p3;
  } exp_t;

  exp_t             q[$];
  exp_t             e;
  exp_t             cur;
  int               n_tests = 0;
  int               n_fail  = 0;
  logic [15:0]      m_count;
  logic             m_terr;
  logic [2:0][31:0] m_p1, m_p2, m_p3;
  bit               hold_valid = 1'b0;
  bit               grab = 1'b0;
  logic             s_rdy, s_rs, s_we, s_busy, s_fd, s_terr;
  logic [15:0]      s_cnt;
  int               lit_we, lit_rs, lit_fd, lit_rc, lit_abort_rc;
  logic             lit_rdy1, lit_terr1;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0][31:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  function automatic exp_t base(input logic b);
    exp_t r;
    r.rdy = 0; r.rs = 0; r.we = 0; r.busy = b; r.fd = 0; r.terr = m_terr;
    r.x = '0; r.y = '0; r.d = '0; r.cnt = m_count;
    r.p1 = m_p1; r.p2 = m_p2; r.p3 = m_p3;
    return r;
  endfunction

  // Single compare process: every cycle with a queued expectation is checked at the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      chk("tri_ready", tri_if.tri_ready, cur.rdy);
      chk("rast_start", rast_start, cur.rs);
      chk("fb_we", fb_we, cur.we);
      chk("fb_x", fb_x, cur.x);
      chk("fb_y", fb_y, cur.y);
      chk("data", data, cur.d);
      chk("busy", busy, cur.busy);
      chk("frame_done", frame_done, cur.fd);
      chk("tri_count", tri_count, cur.cnt);
      chk("timeout_err", timeout_err, cur.terr);
      chk("rast_p1", rast_p1, cur.p1);
      chk("rast_p2", rast_p2, cur.p2);
      chk("rast_p3", rast_p3, cur.p3);
    end
  end

  task automatic step(input exp_t x);
    q.push_back(x);
    @(negedge clk);
    s_rdy = tri_if.tri_ready; s_rs = rast_start; s_we = fb_we; s_busy = busy;
    s_fd = frame_done; s_terr = timeout_err; s_cnt = tri_count;
    if (grab) begin
      lit_terr1 = timeout_err;
      grab = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    frame_start = 0; clear_en = 0; clear_color = 0; rast_done = 1;
    rast_fb_x = 0; rast_fb_y = 0; rast_data = 0; rast_fb_we = 0;
    tri_if.tri_valid = hold_valid; tri_if.tri_last = 0;
    tri_if.tri_p1 = '0; tri_if.tri_p2 = '0; tri_if.tri_p3 = '0;
  endtask

  task automatic noise(input bit noisy, input bit allow_valid);
    rast_fb_x = 10'($urandom); rast_fb_y = 9'($urandom); rast_data = 4'($urandom);
    rast_fb_we = 1'($urandom); rast_done = 1'($urandom);
    frame_start = noisy ? 1'($urandom) : 1'b0;
    tri_if.tri_valid = hold_valid ? 1'b1 : (allow_valid && noisy ? 1'($urandom) : 1'b0);
    tri_if.tri_last = 1'($urandom);
    tri_if.tri_p1 = rnd96(); tri_if.tri_p2 = rnd96(); tri_if.tri_p3 = rnd96();
  endtask

  task automatic idle_step();
    quiet();
    e = base(0);
    step(e);
  endtask

  // One frame: IDLE cycle with frame_start, optional clear pass, ntri triangles, FINISH.
  task automatic run_frame(input bit clr, input logic [3:0] col, input int ntri, input int to_tri,
                           input int stale_f, input int zeros_f, input bit noisy,
                           input int rst_at, input bit fs_in_raster);
    int wait_n, stale, zeros;
    bit seen, done_now, abort;
    logic [2:0][31:0] v1, v2, v3;
    lit_we = 0; lit_rs = 0; lit_fd = 0; lit_rc = 0; lit_abort_rc = 0; lit_rdy1 = 0;
    quiet();
    frame_start = 1; clear_en = clr; clear_color = col;
    e = base(0);
    step(e);
    m_count = 0; m_terr = 0;
    grab = 1'b1;
    if (clr) begin
      for (int i = 0; i < W * H; i++) begin
        noise(noisy, 0);
        if (i == rst_at) reset = 1;
        e = base(1); e.we = 1; e.x = 10'(i % W); e.y = 9'(i / W); e.d = col;
        step(e);
        lit_we += int'(s_we);
        if (i == rst_at) begin
          reset = 0;
          m_count = 0; m_terr = 0; m_p1 = '0; m_p2 = '0; m_p3 = '0;
          return;
        end
      end
    end
    for (int t = 0; t < ntri; t++) begin
      wait_n = hold_valid ? 0 : $urandom_range(0, 3);
      for (int k2 = 0; k2 <= wait_n; k2++) begin
        noise(noisy, 0);
        if (k2 == wait_n) begin
          v1 = rnd96(); v2 = rnd96(); v3 = rnd96();
          tri_if.tri_valid = 1; tri_if.tri_last = (t == ntri - 1);
          tri_if.tri_p1 = v1; tri_if.tri_p2 = v2; tri_if.tri_p3 = v3;
        end else begin
          tri_if.tri_valid = 0;
        end
        e = base(1); e.rdy = 1;
        step(e);
        if (t == 0 && k2 == 0) lit_rdy1 = s_rdy;
      end
      m_p1 = v1; m_p2 = v2; m_p3 = v3;
      noise(noisy, 1);
      rast_done = 1;
      e = base(1); e.rs = 1;
      step(e);
      lit_rs += int'(s_rs);
      stale = (stale_f >= 0) ? stale_f : $urandom_range(0, 2);
      zeros = (t == to_tri) ? 1000000 : ((zeros_f >= 0) ? zeros_f : $urandom_range(1, 6));
      seen = 0;
      for (int k = 0; k < TO; k++) begin
        noise(noisy, 1);
        if (fs_in_raster && k == 1) frame_start = 1;
        rast_done = (k < stale) ? 1'b1 : ((k < stale + zeros) ? 1'b0 : 1'b1);
        done_now = rast_done && seen;
        abort = !done_now && (k == TO - 1);
        e = base(1); e.we = rast_fb_we; e.x = rast_fb_x; e.y = rast_fb_y; e.d = rast_data;
        step(e);
        lit_rc = k + 1;
        seen = seen || !rast_done;
        if (done_now || abort) begin
          if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
          if (abort) begin
            m_terr = 1;
            lit_abort_rc = k + 1;
          end
          break;
        end
      end
    end
    noise(noisy, 1);
    e = base(1); e.fd = 1;
    step(e);
    lit_fd += int'(s_fd);
    quiet();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1;
    quiet();
    m_count = 0; m_terr = 0; m_p1 = '0; m_p2 = '0; m_p3 = '0;
    @(posedge clk);
    #1;
    e = base(0);
    step(e);
    reset = 0;
    chk("reset_busy", s_busy, 1'b0);
    chk("reset_fb_we", s_we, 1'b0);
    chk("reset_tri_count", s_cnt, 16'd0);
    idle_step();

    // 4x3 clear with 0xA, then one triangle: done 1 in LAUNCH, 0 for 5 cycles, then 1.
    run_frame(1, 4'hA, 1, -1, 0, 5, 0, -1, 0);
    idle_step();
    chk("clear_writes", lit_we, 12);
    chk("ready_cycle13", lit_rdy1, 1'b1);
    chk("one_tri_starts", lit_rs, 1);
    chk("one_tri_frame_done", lit_fd, 1);
    chk("one_tri_raster_cycles", lit_rc, 6);
    chk("one_tri_count", s_cnt, 16'd1);

    // Three triangles with tri_valid held high throughout.
    hold_valid = 1;
    run_frame(0, 4'h3, 3, -1, -1, -1, 1, -1, 0);
    hold_valid = 0;
    idle_step();
    chk("three_tri_starts", lit_rs, 3);
    chk("three_tri_count", s_cnt, 16'd3);

    // First triangle times out, second completes normally.
    run_frame(0, 4'h0, 2, 0, -1, -1, 0, -1, 0);
    idle_step();
    chk("timeout_cycles", lit_abort_rc, TO);
    chk("timeout_err_set", s_terr, 1'b1);
    chk("timeout_count", s_cnt, 16'd2);

    // frame_start pulsed during RASTER must be ignored; terr from previous frame cleared at start.
    run_frame(0, 4'h5, 1, -1, -1, -1, 0, -1, 1);
    idle_step();
    chk("terr_cleared_on_start", lit_terr1, 1'b0);
    chk("fs_in_raster_count", s_cnt, 16'd1);
    chk("fs_in_raster_terr", s_terr, 1'b0);

    // Reset in the middle of the clear pass at pixel (1,2), then a full restart.
    run_frame(1, 4'h7, 1, -1, -1, -1, 0, 9, 0);
    idle_step();
    chk("reset_mid_clear_busy", s_busy, 1'b0);
    chk("reset_mid_clear_we", s_we, 1'b0);
    run_frame(1, 4'hC, 2, -1, -1, -1, 0, -1, 0);
    idle_step();
    chk("restart_clear_writes", lit_we, 12);

    // Randomized frames with noisy inputs.
    for (int f = 0; f < 8; f++) begin
      run_frame(1'($urandom), 4'($urandom), $urandom_range(1, 3),
                ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2) : -1,
                -1, -1, 1, -1, 1'($urandom));
      for (int g = 0; g < $urandom_range(1, 3); g++) idle_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
